// File: rtl/lut_stim_check.sv
`timescale 1ns/1ps
// Exhaustive truth-table checker for an external LUT: steps through every input vector,
// lets the LUT settle, samples its output and tallies mismatches against INIT.
module lut_stim_check #(
  parameter int                         N_INPUTS      = 1,
  parameter logic [(1<<N_INPUTS)-1:0]   INIT          = 2'b01,
  parameter int                         SETTLE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic [N_INPUTS-1:0] lut_i,
  input  logic                lut_o,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [7:0]          err_count,
  output logic [N_INPUTS-1:0] first_fail
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  state_t              state_q, state_d;
  logic [N_INPUTS-1:0] vec_q;
  logic [7:0]          settle_cnt;
  logic                fail_seen;
  logic                vec_last;
  logic                mismatch;

  assign vec_last = &vec_q;
  assign mismatch = (state_q == SAMPLE) && (lut_o != INIT[vec_q]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = SETTLE;
      SETTLE:     if (settle_cnt == SETTLE_LAST) state_d = SAMPLE;
      SAMPLE:     state_d = vec_last ? DONE : SETTLE;
      default:    state_d = IDLE;
    endcase
  end

  // Datapath; the vector only moves on the SAMPLE->SETTLE hand-off, so lut_i is stable
  // for the whole settle/sample window of each vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_q      <= '0;
      settle_cnt <= '0;
      err_count  <= '0;
      first_fail <= '0;
      fail_seen  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: if (start) begin
          vec_q      <= '0;
          settle_cnt <= '0;
          err_count  <= '0;
          first_fail <= '0;
          fail_seen  <= 1'b0;
        end
        SETTLE: settle_cnt <= settle_cnt + 8'd1;
        SAMPLE: begin
          if (mismatch) begin
            if (err_count != 8'hff) err_count <= err_count + 8'd1;
            if (!fail_seen) begin
              first_fail <= vec_q;
              fail_seen  <= 1'b1;
            end
          end
          settle_cnt <= '0;
          if (!vec_last) vec_q <= vec_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign lut_i = vec_q;
  assign busy  = (state_q == SETTLE) || (state_q == SAMPLE);
  assign done  = (state_q == DONE);
  assign pass  = (state_q == DONE) && (err_count == 8'd0);

endmodule

// File: tb/tb_lut_stim_check.sv
`timescale 1ns/1ps
// Scoreboard bench: stimulus queues the expected per-cycle vectors and run results,
// a negedge monitor pops and compares whenever the checkers are busy or finish a run.
module tb_lut_stim_check;

  typedef struct {
    logic [7:0] err;
    logic [3:0] ff;
    logic       pass;
    int         cyc;
  } res_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start0, start1, stuck;
  logic [0:0] lut_i0, ff0;
  logic [1:0] lut_i1, ff1;
  logic       lut_o0, lut_o1;
  logic       busy0, done0, pass0, busy1, done1, pass1;
  logic [7:0] err0, err1;
  logic       done0_d = 1'b0, done1_d = 1'b0;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  res_t q0[$], q1[$];
  int   lq0[$], lq1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Device models: an inverter (optionally stuck at 0) and an OR2 against an AND2 table.
  assign lut_o0 = stuck ? 1'b0 : ~lut_i0[0];
  assign lut_o1 = |lut_i1;

  lut_stim_check dut0 (
    .clk(clk), .rst(rst), .start(start0), .lut_i(lut_i0), .lut_o(lut_o0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .first_fail(ff0)
  );

  lut_stim_check #(.N_INPUTS(2), .INIT(4'b1000), .SETTLE_CYCLES(2)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .lut_i(lut_i1), .lut_o(lut_o1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .first_fail(ff1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // base = cycle count just after the accepting edge
  task automatic exp0(input int base, input logic [7:0] e, input logic [3:0] f, input logic p);
    for (int v = 0; v < 2; v++)
      for (int k = 0; k < 5; k++) lq0.push_back(v);
    q0.push_back('{err: e, ff: f, pass: p, cyc: base + 10});
  endtask

  task automatic exp1(input int base, input logic [7:0] e, input logic [3:0] f, input logic p);
    for (int v = 0; v < 4; v++)
      for (int k = 0; k < 3; k++) lq1.push_back(v);
    q1.push_back('{err: e, ff: f, pass: p, cyc: base + 12});
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk("drain_pending", q0.size() + q1.size(), 0);
    chk("lut_pending", lq0.size() + lq1.size(), 0);
  endtask

  task automatic pulse0(input logic [7:0] e, input logic [3:0] f, input logic p);
    @(posedge clk); #1;
    start0 = 1'b1;
    exp0(cyc + 1, e, f, p);
    @(posedge clk); #1;
    start0 = 1'b0;
  endtask

  always @(negedge clk) begin
    res_t r;
    if (!rst) begin
      if (busy0) begin
        if (lq0.size() == 0) chk("lut0_unexpected", 1, 0);
        else chk("lut0_vec", lut_i0, lq0.pop_front());
        chk("flags0_busy", {done0, pass0}, 0);
      end
      if (done0 && !done0_d) begin
        if (q0.size() == 0) chk("done0_unexpected", 1, 0);
        else begin
          r = q0.pop_front();
          chk("done0_cycle", cyc, r.cyc);
          chk("err0", err0, r.err);
          chk("ff0", ff0, r.ff);
          chk("pass0", pass0, r.pass);
        end
      end
      if (busy1) begin
        if (lq1.size() == 0) chk("lut1_unexpected", 1, 0);
        else chk("lut1_vec", lut_i1, lq1.pop_front());
        chk("flags1_busy", {done1, pass1}, 0);
      end
      if (done1 && !done1_d) begin
        if (q1.size() == 0) chk("done1_unexpected", 1, 0);
        else begin
          r = q1.pop_front();
          chk("done1_cycle", cyc, r.cyc);
          chk("err1", err1, r.err);
          chk("ff1", ff1, r.ff);
          chk("pass1", pass1, r.pass);
        end
      end
    end
    done0_d <= done0;
    done1_d <= done1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int base;
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; stuck = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_lut0", lut_i0, 0);
    chk("rst_flags0", {busy0, done0, pass0}, 0);
    chk("rst_err0", err0, 0);
    chk("rst_ff0", ff0, 0);
    chk("rst_lut1", lut_i1, 0);
    chk("rst_flags1", {busy1, done1, pass1}, 0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_no_start", {busy0, done0, busy1, done1}, 0);

    // Correct inverter, then a re-run after done
    pulse0(8'd0, 4'd0, 1'b1);
    drain(40);
    pulse0(8'd0, 4'd0, 1'b1);
    drain(40);

    // Stuck-at-0 inverter: only vector 0 mismatches
    stuck = 1'b1;
    pulse0(8'd1, 4'd0, 1'b0);
    drain(40);
    stuck = 1'b0;

    // start pulses at edges 3 and 7 during the run are ignored
    pulse0(8'd0, 4'd0, 1'b1);       // leaves us just after edge 1
    @(posedge clk); #1;             // after edge 2
    start0 = 1'b1;
    @(posedge clk); #1;             // after edge 3
    start0 = 1'b0;
    repeat (3) @(posedge clk);      // after edge 6
    #1;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    drain(40);

    // AND2 table checked against an OR2 device, then re-run clears results on accept
    @(posedge clk); #1;
    start1 = 1'b1;
    exp1(cyc + 1, 8'd2, 4'd1, 1'b0);
    @(posedge clk); #1;
    start1 = 1'b0;
    drain(40);
    @(posedge clk); #1;
    start1 = 1'b1;
    exp1(cyc + 1, 8'd2, 4'd1, 1'b0);
    @(posedge clk); #1;
    chk("rerun_err1_cleared", err1, 0);
    chk("rerun_ff1_cleared", ff1, 0);
    start1 = 1'b0;
    drain(40);

    // start held high: back-to-back runs, next one accepted the edge after done
    @(posedge clk); #1;
    start0 = 1'b1;
    base = cyc + 1;
    exp0(base, 8'd0, 4'd0, 1'b1);
    exp0(base + 11, 8'd0, 4'd0, 1'b1);
    while (cyc < base + 12) @(posedge clk);
    #1;
    start0 = 1'b0;
    drain(60);

    // Asynchronous reset during settle of vector 1 aborts the run
    @(posedge clk); #1;
    start0 = 1'b1;
    base = cyc + 1;
    exp0(base, 8'd0, 4'd0, 1'b1);
    @(posedge clk); #1;
    start0 = 1'b0;
    while (cyc < base + 6) @(posedge clk);
    #2;
    rst = 1'b1;
    q0.delete();
    lq0.delete();
    #1;
    chk("abort_lut0", lut_i0, 0);
    chk("abort_flags0", {busy0, done0, pass0}, 0);
    chk("abort_err0", err0, 0);
    chk("abort_ff0", ff0, 0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_stays_idle", {busy0, done0, pass0}, 0);
    pulse0(8'd0, 4'd0, 1'b1);
    drain(40);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
